multdiv: RTL and testbench

MULTDIV -- requirements
Module: multdiv

---
 rtl/multdiv.sv | 94 +++++++++
 tb/tb_multdiv.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/multdiv.sv
// multdiv: iterative signed 32x32 multiply / restoring divide with a fixed 33-edge latency.
module multdiv (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d, res_q, res_d;
  logic        neg_q, neg_d, dz_q, dz_d, exc_q, exc_d;
  logic        start, ge;
  logic [31:0] mag_a, mag_b, dsub, quo;
  logic [32:0] madd, dsh;
  logic [63:0] prod;
  assign start = ctrl_MULT | ctrl_DIV;
  assign mag_a = data_operandA[31] ? -data_operandA : data_operandA;
  assign mag_b = data_operandB[31] ? -data_operandB : data_operandB;
  // Multiply: acc = {partial hi, multiplier}, shift-add on magnitudes
  assign madd  = {1'b0, acc_q[63:32]} + {1'b0, acc_q[0] ? b_q : 32'd0};
  // Divide: acc = {remainder, dividend/quotient}; remainder < divisor <= 2^31 fits 32 bits
  assign dsh   = acc_q[63:31];
  assign ge    = dsh >= {1'b0, b_q};
  assign dsub  = ge ? dsh[31:0] - b_q : dsh[31:0];
  assign prod  = neg_q ? -acc_q : acc_q;
  assign quo   = neg_q ? -acc_q[31:0] : acc_q[31:0];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    res_d   = res_q;
    exc_d   = exc_q;
    if (start) begin
      state_d = ctrl_MULT ? MULT : DIV;
      cnt_d   = 6'd0;
      acc_d   = {32'd0, ctrl_MULT ? mag_b : mag_a};
      b_d     = ctrl_MULT ? mag_a : mag_b;
      neg_d   = data_operandA[31] ^ data_operandB[31];
      dz_d    = ~|data_operandB;
    end else begin
      case (state_q)
        MULT, DIV: begin
          if (cnt_q[5]) begin
            state_d = DONE;
            res_d   = (state_q == MULT) ? prod[31:0] : (dz_q ? 32'd0 : quo);
            exc_d   = (state_q == MULT) ? ~(&prod[63:31] | ~|prod[63:31])
                                        : (dz_q | (~neg_q & acc_q[31]));
          end else begin
            acc_d = (state_q == MULT) ? {madd, acc_q[31:1]} : {dsub, acc_q[30:0], ge};
            cnt_d = cnt_q + 6'd1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end
  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = state_q == DONE;
  assign busy           = state_q != IDLE;
endmodule

// File: tb/tb_multdiv.sv
// tb_multdiv: randomized and directed checks of multdiv against a 64-bit arithmetic model.
module tb_multdiv;
  logic        clock, reset, ctrl_MULT, ctrl_DIV;
  logic [31:0] opa, opb, data_result;
  logic        data_exception, data_resultRDY, busy;
  int          checks, errors;
  logic [31:0] prev_res;
  multdiv dut (
    .clock(clock), .reset(reset),
    .data_operandA(opa), .data_operandB(opb),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint sa, sb, p, t;
    sa = $signed(a);
    sb = $signed(b);
    if (!m && b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else begin
      p = m ? sa * sb : sa / sb;
      t = $signed(p[31:0]);
      r = p[31:0];
      e = p != t;
    end
  endfunction
  task automatic start(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT = m;
    ctrl_DIV  = d;
    opa = a;
    opb = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    opa = $urandom;
    opb = $urandom;
  endtask
  task automatic wait_done(input string tag, input logic [31:0] er, input logic ee);
    int n;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
      if (n == 1) chk({tag, "_busy"}, busy, 1);
      if (n == 10) chk({tag, "_hold"}, data_result, prev_res);
    end while (!data_resultRDY && n < 40);
    chk({tag, "_lat"}, n, 33);
    chk({tag, "_res"}, data_result, er);
    chk({tag, "_exc"}, data_exception, ee);
    prev_res = er;
    @(posedge clock);
    #1;
    chk({tag, "_rdy_pulse"}, data_resultRDY, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask
  task automatic run(input string tag, input bit m, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic        ee;
    model(m, a, b, er, ee);
    start(m, !m, a, b);
    wait_done(tag, er, ee);
  endtask
  initial begin
    logic [31:0] er, a, b;
    logic        ee;
    int          rdys;
    checks = 0;
    errors = 0;
    prev_res = 32'd0;
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    opa = 32'd0;
    opb = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_res", data_result, 0);
    chk("rst_exc", data_exception, 0);
    chk("rst_rdy", data_resultRDY, 0);
    chk("rst_busy", busy, 0);
    run("mul_7x-3", 1, 32'd7, -32'sd3);
    chk("mul_7x-3_val", prev_res, 32'hFFFFFFEB);
    run("mul_ovf", 1, 32'h00010000, 32'h00010000);
    run("div_-7/2", 0, -32'sd7, 32'd2);
    chk("div_-7/2_val", prev_res, 32'hFFFFFFFD);
    run("div_5/0", 0, 32'd5, 32'd0);
    run("div_min/-1", 0, 32'h80000000, 32'hFFFFFFFF);
    start(1, 0, 32'd3, 32'd4);
    repeat (9) begin
      @(posedge clock);
      #1;
      chk("abort_no_rdy", data_resultRDY, 0);
    end
    start(0, 1, 32'd100, 32'd10);
    wait_done("abort_div", 32'd10, 1'b0);
    start(1, 0, 32'd5, 32'd6);
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    prev_res = 32'd0;
    chk("midrst_res", data_result, 0);
    chk("midrst_exc", data_exception, 0);
    chk("midrst_rdy", data_resultRDY, 0);
    chk("midrst_busy", busy, 0);
    rdys = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      rdys += int'(data_resultRDY);
    end
    chk("midrst_no_rdy", rdys, 0);
    reset = 1'b1;
    ctrl_MULT = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    ctrl_MULT = 1'b0;
    chk("rst_prio_busy", busy, 0);
    model(1, 32'd7, -32'sd3, er, ee);
    start(1, 1, 32'd7, -32'sd3);
    wait_done("both_ctrl", er, ee);
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = $urandom_range(0, 31) - 16;
        3: begin b = $urandom_range(0, 200) - 100; a = $urandom_range(0, 2000) - 1000; end
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      run($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, b);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
